// File: rtl/cpu_pkg.sv
// Shared CPU widths, fetch defaults and the buffered instruction entry.
package cpu_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle.
// The memory side and the decode side share this interface; the fetch unit is the master.
interface fetch_unit_if;
  import cpu_pkg::*;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_busy;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [WORD_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output mem_addr, instr_valid, instr_data, instr_pc,
    input  mem_rdata, mem_busy, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  mem_addr, instr_valid, instr_data, instr_pc,
    output mem_rdata, mem_busy, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries.
// Flush has priority over push and pop and returns the FIFO to its empty state.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);
  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
      if (i_pop) assert (r_count != '0) else $error("fetch_fifo underflow");
      if (i_push && !i_pop) assert (r_count != CW'(DEPTH)) else $error("fetch_fifo overflow");
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, memory read capture and redirect control feeding a prefetch FIFO.
// A full FIFO may still push when it pops in the same cycle, sustaining one instruction per cycle.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  fetch_entry_t      w_head, w_wdata;
  logic [CW-1:0]     w_count;
  logic              w_full, w_empty, w_push, w_pop;

  assign w_pop   = !w_empty && bus.instr_ready && !bus.redirect_valid;
  assign w_push  = !bus.mem_busy && !bus.redirect_valid && (!w_full || w_pop);
  assign w_wdata = '{instr: bus.mem_rdata, pc: r_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_pc <= RESET_PC;
    else if (bus.redirect_valid) r_pc <= bus.redirect_pc;
    else if (w_push)             r_pc <= r_pc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (w_count <= CW'(DEPTH)) else $error("fetch count out of range");
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.mem_addr    = r_pc;
  assign bus.instr_valid = !w_empty;
  assign bus.instr_data  = w_empty ? '0 : w_head.instr;
  assign bus.instr_pc    = w_empty ? '0 : w_head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 256-word combinational-read memory model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] ram [256];
  logic [15:0] exp_d [4];

  fetch_unit_if bif ();
  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  always #5 clk = ~clk;
  assign bif.mem_rdata = ram[bif.mem_addr[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] d, input logic [15:0] pc);
    chk({tag, "_valid"}, {31'd0, bif.instr_valid}, 32'd1);
    chk({tag, "_data"},  {16'd0, bif.instr_data},  {16'd0, d});
    chk({tag, "_pc"},    {16'd0, bif.instr_pc},    {16'd0, pc});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, bif.instr_valid}, 32'd0);
    chk({tag, "_data"},  {16'd0, bif.instr_data},  32'd0);
    chk({tag, "_pc"},    {16'd0, bif.instr_pc},    32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4444;
    ram[8'h80] = 16'h8080; ram[8'h81] = 16'h8181;
    ram[8'hFE] = 16'hBEEF; ram[8'hFF] = 16'hCAFE;
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    bif.mem_busy = 1'b0; bif.redirect_valid = 1'b0; bif.redirect_pc = 16'h0; bif.instr_ready = 1'b1;

    // reset state
    tick(); tick();
    chk_empty("rst");
    chk("rst_addr", {16'd0, bif.mem_addr}, 32'h0);
    rst_n = 1'b1;

    // streaming from reset, one per cycle
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_head($sformatf("stream%0d", k), exp_d[k], 16'(k));
    end

    // refill at pc 0 with decode stalled: saturates at 4 entries
    bif.redirect_valid = 1'b1; bif.redirect_pc = 16'h0000; bif.instr_ready = 1'b0;
    tick();
    chk("stall_flush_valid", {31'd0, bif.instr_valid}, 32'd0);
    bif.redirect_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk_head("stall_head", 16'h1111, 16'h0000);
    chk("stall_addr", {16'd0, bif.mem_addr}, 32'h4);
    bif.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("drain%0d", k), exp_d[k], 16'(k));
      tick();
    end
    chk_head("drain4", 16'hA004, 16'h0004);
    tick();
    chk_head("drain5", 16'hA005, 16'h0005);

    // mem_busy bubble on a single-entry stream
    bif.redirect_valid = 1'b1; bif.redirect_pc = 16'h0010;
    tick();
    bif.redirect_valid = 1'b0;
    tick();
    chk_head("busy_pre", 16'hA010, 16'h0010);
    bif.mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("busy_bubble%0d", k), {31'd0, bif.instr_valid}, 32'd0);
      chk($sformatf("busy_addr%0d", k), {16'd0, bif.mem_addr}, 32'h11);
    end
    bif.mem_busy = 1'b0;
    tick();
    chk_head("busy_post0", 16'hA011, 16'h0011);
    tick();
    chk_head("busy_post1", 16'hA012, 16'h0012);

    // redirect on a full FIFO with ready high: nothing delivered
    bif.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_head("full_head", 16'hA012, 16'h0012);
    bif.instr_ready = 1'b1; bif.redirect_valid = 1'b1; bif.redirect_pc = 16'h0080;
    tick();
    chk("redir_valid", {31'd0, bif.instr_valid}, 32'd0);
    chk("redir_addr", {16'd0, bif.mem_addr}, 32'h80);
    bif.redirect_valid = 1'b0;
    tick();
    chk_head("redir0", 16'h8080, 16'h0080);
    tick();
    chk_head("redir1", 16'h8181, 16'h0081);

    // PC wrap
    bif.redirect_valid = 1'b1; bif.redirect_pc = 16'hFFFE;
    tick();
    bif.redirect_valid = 1'b0;
    tick(); chk_head("wrap0", 16'hBEEF, 16'hFFFE);
    tick(); chk_head("wrap1", 16'hCAFE, 16'hFFFF);
    tick(); chk_head("wrap2", 16'h1111, 16'h0000);
    tick(); chk_head("wrap3", 16'h2222, 16'h0001);

    // back-to-back redirects: last wins
    bif.redirect_valid = 1'b1; bif.redirect_pc = 16'h0040;
    tick();
    bif.redirect_pc = 16'h0020;
    tick();
    bif.redirect_valid = 1'b0;
    tick();
    chk_head("b2b", 16'hA020, 16'h0020);

    // asynchronous reset with two entries buffered
    bif.instr_ready = 1'b0;
    tick();
    chk_head("half_head", 16'hA020, 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("async_rst");
    chk("async_rst_addr", {16'd0, bif.mem_addr}, 32'h0);
    tick();
    rst_n = 1'b1; bif.instr_ready = 1'b1;
    tick(); chk_head("restart0", 16'h1111, 16'h0000);
    tick(); chk_head("restart1", 16'h2222, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the 16-bit word-addressed unified memory (256 x 16, combinational read, synchronous write). It drives the memory read address from its program counter, captures the returned word in the same cycle, and buffers the instructions with their PCs in a small prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. Branch/jump redirects flush the FIFO and reload the PC.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_addr  output  16  read address to memory; always equals fetch_pc
mem_rdata  input  16  memory data_out, combinationally valid for mem_addr
mem_busy  input  1  memory port taken by load/store this cycle; fetch must not capture
redirect_valid  input  1  control-flow change from execute
redirect_pc  input  16  new fetch target
instr_valid  output  1  FIFO head holds an instruction
instr_data  output  16  instruction word at FIFO head
instr_pc  output  16  PC of instr_data
instr_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst_n low, asynchronous): fetch_pc = RESET_PC, FIFO count = 0, read/write pointers = 0; instr_valid = 0, instr_data = 0, instr_pc = 0 (outputs read as 0 whenever FIFO empty). mem_addr = RESET_PC during reset.
- mem_addr = fetch_pc combinationally; no extra register. Latency: word at fetch_pc captured at end of cycle N, visible on instr_* in cycle N+1.
- pop = instr_valid && instr_ready && !redirect_valid.
- push = !mem_busy && !redirect_valid && (count < DEPTH || pop). Full FIFO with simultaneous pop is allowed to push (sustains 1 instr/cycle).
- On push: entry {mem_rdata, fetch_pc} written at write pointer; fetch_pc <= fetch_pc + 1, 16-bit wrap (16'hFFFF -> 16'h0000).
- On pop: read pointer advances. count += push - pop.
- instr_data/instr_pc are driven from the FIFO head (registered storage, no combinational path from mem_rdata).
- redirect_valid (highest priority): count <= 0, pointers reset, fetch_pc <= redirect_pc; no push, no pop that cycle; instr_ready ignored. Next cycle fetches redirect_pc.
- mem_busy: fetch_pc and FIFO contents hold; pops continue normally.
- Back-to-back redirects: last one wins; each cycle reloads fetch_pc.
- Reset mid-operation: all state cleared immediately; buffered instructions discarded.
- Never underflow (pop only when count > 0) or overflow (guaranteed by push term); assertions on both.

Decomposition:
- Shared package cpu_pkg: WORD_W = 16, ADDR_W = 16, default RESET_PC, instruction/PC entry struct {instr, pc}.
- One sub-module: fetch_fifo (synchronous FIFO, DEPTH entries of {instr, pc}, push/pop/flush, count/full/empty); fetch_unit holds PC and control.

Test Plan:
- Reset release, mem preloaded ram[0..3] = 16'h1111,16'h2222,16'h3333,16'h4444, instr_ready=1 -> instr_valid first high cycle 1 after reset, stream 1111@pc0, 2222@pc1, 3333@pc2, 4444@pc3 one per cycle.
- instr_ready=0 for 10 cycles -> count saturates at 4, fetch_pc stops at 4, mem_addr=4; then ready=1 -> pcs 0..3 delivered in order with no gap, then pc 4.
- mem_busy high 3 cycles mid-stream -> no pushes, fetch_pc frozen, exactly 3-cycle bubble, no duplicated or skipped PC.
- FIFO full, redirect_valid with redirect_pc=16'h0080 and instr_ready=1 same cycle -> no pop delivered, instr_valid=0 next cycle, then instr_pc=16'h0080 the cycle after.
- redirect_pc=16'hFFFE, ready=1 -> pcs FFFE, FFFF, 0000, 0001 (wrap).
- Assert rst_n low with FIFO half full -> instr_valid drops immediately (asynchronously), fetch_pc=RESET_PC; after release, fetching restarts at RESET_PC.
